initmem_word_writer: RTL and testbench

//  Downstream stage of the SD boot loader. Accepts 32-bit words over the loader's WE / ctrl_state handshake.

---
 rtl/initmem_pkg.sv | 19 +
 rtl/initmem_wfifo.sv | 43 ++++
 rtl/initmem_word_writer.sv | 135 +++++++++++++
 tb/tb_initmem_word_writer.sv | 230 +++++++++++++++++++++++
 4 files changed

// File: rtl/initmem_pkg.sv
// Shared encodings for the SD boot loader's memory-init write stage:
// loader handshake states, write FSM states and word size.
package initmem_pkg;

    typedef enum logic [7:0] {
        CS_READY  = 8'd0,
        CS_ACCEPT = 8'd1,
        CS_FULL   = 8'd2,
        CS_DONE   = 8'd3
    } cs_t;

    typedef enum logic {
        M_IDLE = 1'b0,
        M_REQ  = 1'b1
    } ws_t;

    localparam int WORD_BYTES = 4;

endpackage

// File: rtl/initmem_wfifo.sv
// Synchronous 32-bit word FIFO with show-ahead read data.
// Pointers carry an extra MSB so full and empty are distinguishable.
module initmem_wfifo #(
    parameter int DEPTH = 4
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        push,
    input  logic        pop,
    input  logic [31:0] wdata,
    output logic [31:0] rdata,
    output logic        full,
    output logic        empty
);
    localparam int AW = $clog2(DEPTH);

    logic [31:0] mem [DEPTH];
    logic [AW:0] wr_ptr;
    logic [AW:0] rd_ptr;

    assign empty = (wr_ptr == rd_ptr);
    assign full  = (wr_ptr[AW] != rd_ptr[AW]) &&
                   (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign rdata = mem[rd_ptr[AW-1:0]];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (push && !full)
                wr_ptr <= wr_ptr + 1'b1;
            if (pop && !empty)
                rd_ptr <= rd_ptr + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (push && !full)
            mem[wr_ptr[AW-1:0]] <= wdata;
    end

endmodule

// File: rtl/initmem_word_writer.sv
// Boot loader word sink: buffers words and commits them to memory.
// Build option INITMEM_CHECKSUM_EN enables the running write checksum.
module initmem_word_writer
    import initmem_pkg::*;
#(
    parameter int                ADDR_W     = 32,
    parameter logic [ADDR_W-1:0] BASE_ADDR  = '0,
    parameter int                FIFO_DEPTH = 4,
    parameter logic [31:0]       MAX_WORDS  = 32'h0004_0000
) (
    input  logic              clk27mhz,
    input  logic              resetn,
    input  logic [31:0]       word_data,
    input  logic              word_we,
    input  logic              loader_done,
    output logic [7:0]        ctrl_state,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [31:0]       mem_wdata,
    output logic              mem_req,
    input  logic              mem_ack,
    output logic              init_done,
    output logic [31:0]       word_count,
    output logic [31:0]       checksum
);
    cs_t         cs;
    ws_t         ws;
    logic [31:0] accepted;
    logic [31:0] fifo_rdata;
    logic        fifo_full;
    logic        fifo_empty;
    logic        push;
    logic        pop;
    logic        commit;

    // Words beyond MAX_WORDS still complete the handshake but never enter the FIFO
    assign push = (cs == CS_READY) && word_we && !fifo_full &&
                  (accepted < MAX_WORDS);
    assign pop    = (ws == M_IDLE) && !fifo_empty;
    assign commit = (ws == M_REQ) && mem_ack;
    assign ctrl_state = cs;

    initmem_wfifo #(
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk   (clk27mhz),
        .rst_n (resetn),
        .push  (push),
        .pop   (pop),
        .wdata (word_data),
        .rdata (fifo_rdata),
        .full  (fifo_full),
        .empty (fifo_empty)
    );

    always_ff @(posedge clk27mhz or negedge resetn) begin
        if (!resetn) begin
            cs        <= CS_READY;
            accepted  <= '0;
            init_done <= 1'b0;
        end else begin
            unique case (cs)
                CS_READY: begin
                    if (word_we) begin
                        if (!fifo_full) begin
                            cs <= CS_ACCEPT;
                            if (accepted < MAX_WORDS)
                                accepted <= accepted + 32'd1;
                        end else begin
                            cs <= CS_FULL;
                        end
                    end else if (loader_done && fifo_empty && !mem_req) begin
                        cs        <= CS_DONE;
                        init_done <= 1'b1;
                    end
                end
                CS_ACCEPT: begin
                    if (!word_we)
                        cs <= (fifo_full && !pop) ? CS_FULL : CS_READY;
                end
                CS_FULL: begin
                    if (!fifo_full || pop)
                        cs <= CS_READY;
                end
                CS_DONE: cs <= CS_DONE;
                default: cs <= CS_READY;
            endcase
        end
    end

    always_ff @(posedge clk27mhz or negedge resetn) begin
        if (!resetn) begin
            ws         <= M_IDLE;
            mem_req    <= 1'b0;
            mem_addr   <= BASE_ADDR;
            mem_wdata  <= '0;
            word_count <= '0;
        end else begin
            unique case (ws)
                M_IDLE: begin
                    if (!fifo_empty) begin
                        mem_wdata <= fifo_rdata;
                        mem_req   <= 1'b1;
                        ws        <= M_REQ;
                    end
                end
                M_REQ: begin
                    if (mem_ack) begin
                        mem_req    <= 1'b0;
                        mem_addr   <= mem_addr + ADDR_W'(WORD_BYTES);
                        word_count <= word_count + 32'd1;
                        ws         <= M_IDLE;
                    end
                end
            endcase
        end
    end

`ifdef INITMEM_CHECKSUM_EN
    logic [31:0] sum_q;

    always_ff @(posedge clk27mhz or negedge resetn) begin
        if (!resetn)
            sum_q <= '0;
        else if (commit)
            sum_q <= sum_q + mem_wdata;
    end

    assign checksum = sum_q;
`else
    logic unused_commit;
    assign unused_commit = commit;
    assign checksum = 32'h0;
`endif

endmodule

// File: tb/tb_initmem_word_writer.sv
// Scoreboard bench for initmem_word_writer: directed loader traffic,
// a stalling memory responder and an in-order write monitor.
module tb_initmem_word_writer;

    localparam logic [31:0] BASE = 32'hFFFF_FFF8;

    logic        clk = 1'b0;
    logic        resetn = 1'b0;
    logic [31:0] word_data = '0;
    logic        word_we = 1'b0;
    logic        loader_done = 1'b0;
    logic [7:0]  ctrl_state;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic        mem_req;
    logic        mem_ack = 1'b0;
    logic        init_done;
    logic [31:0] word_count;
    logic [31:0] checksum;

    int          checks = 0;
    int          errors = 0;
    logic [63:0] exp_q [$];
    logic [31:0] exp_addr;
    logic [31:0] exp_sum;
    bit          stall = 1'b0;
    int          ack_delay = 0;
    int          wait_cnt = 0;

    initmem_word_writer #(
        .ADDR_W     (32),
        .BASE_ADDR  (BASE),
        .FIFO_DEPTH (4),
        .MAX_WORDS  (32'd6)
    ) dut (
        .clk27mhz    (clk),
        .resetn      (resetn),
        .word_data   (word_data),
        .word_we     (word_we),
        .loader_done (loader_done),
        .ctrl_state  (ctrl_state),
        .mem_addr    (mem_addr),
        .mem_wdata   (mem_wdata),
        .mem_req     (mem_req),
        .mem_ack     (mem_ack),
        .init_done   (init_done),
        .word_count  (word_count),
        .checksum    (checksum)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] act,
                       input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Memory responder and write monitor: compares each acknowledged write
    always @(negedge clk) begin
        if (!resetn) begin
            mem_ack = 1'b0;
            wait_cnt = 0;
        end else if (mem_ack) begin
            mem_ack = 1'b0;
        end else if (mem_req && !stall) begin
            if (wait_cnt >= ack_delay) begin
                mem_ack = 1'b1;
                wait_cnt = 0;
                if (exp_q.size() == 0) begin
                    chk("unexpected_write", {mem_addr, mem_wdata}, 64'h0);
                end else begin
                    chk("write_addr_data", {mem_addr, mem_wdata},
                        exp_q.pop_front());
                end
            end else begin
                wait_cnt++;
            end
        end
    end

    task automatic do_reset();
        resetn = 1'b0;
        word_we = 1'b0;
        loader_done = 1'b0;
        stall = 1'b0;
        ack_delay = 0;
        exp_q.delete();
        exp_addr = BASE;
        exp_sum = '0;
        repeat (2) @(negedge clk);
        resetn = 1'b1;
        @(negedge clk);
    endtask

    task automatic send(input logic [31:0] d, input int hold,
                        input bit stored);
        int i;
        for (i = 0; i < 500 && ctrl_state != 8'd0; i++)
            @(negedge clk);
        if (ctrl_state != 8'd0) begin
            chk("ready_timeout", {56'h0, ctrl_state}, 64'h0);
            return;
        end
        word_data = d;
        word_we = 1'b1;
        if (stored) begin
            exp_q.push_back({exp_addr, d});
            exp_addr = exp_addr + 32'd4;
            exp_sum = exp_sum + d;
        end
        @(negedge clk);
        chk("accept_state", {56'h0, ctrl_state}, 64'd1);
        if (hold > 0) begin
            repeat (hold) @(negedge clk);
            chk("hold_state", {56'h0, ctrl_state}, 64'd1);
        end
        word_we = 1'b0;
        @(negedge clk);
    endtask

    task automatic finish_load(input logic [31:0] n);
        int i;
        loader_done = 1'b1;
        for (i = 0; i < 500 && !init_done; i++)
            @(negedge clk);
        chk("init_done", {63'h0, init_done}, 64'd1);
        chk("done_state", {56'h0, ctrl_state}, 64'd3);
        chk("word_count", {32'h0, word_count}, {32'h0, n});
        chk("queue_drained", 64'(exp_q.size()), 64'd0);
`ifdef INITMEM_CHECKSUM_EN
        chk("checksum", {32'h0, checksum}, {32'h0, exp_sum});
`else
        chk("checksum", {32'h0, checksum}, 64'h0);
`endif
    endtask

    initial begin
        int i;
        exp_addr = BASE;
        exp_sum = '0;

        // Reset values
        do_reset();
        chk("rst_state", {56'h0, ctrl_state}, 64'd0);
        chk("rst_req", {63'h0, mem_req}, 64'd0);
        chk("rst_addr", {32'h0, mem_addr}, {32'h0, BASE});
        chk("rst_wdata", {32'h0, mem_wdata}, 64'h0);
        chk("rst_done", {63'h0, init_done}, 64'd0);
        chk("rst_count", {32'h0, word_count}, 64'h0);
        chk("rst_checksum", {32'h0, checksum}, 64'h0);

        // Single word, slow ack
        ack_delay = 3;
        send(32'hDEAD_BEEF, 0, 1'b1);
        chk("t1_back_to_ready", {56'h0, ctrl_state}, 64'd0);
        for (i = 0; i < 100 && word_count != 32'd1; i++)
            @(negedge clk);
        finish_load(32'd1);
        chk("t1_next_addr", {32'h0, mem_addr}, 64'hFFFF_FFFC);

        // WE held in ACCEPT: one push only
        do_reset();
        send(32'h1234_5678, 5, 1'b1);
        chk("t2_ready", {56'h0, ctrl_state}, 64'd0);
        finish_load(32'd1);

        // Stalled memory fills the FIFO; MAX_WORDS drops the 7th word
        do_reset();
        stall = 1'b1;
        for (int w = 0; w < 5; w++)
            send(32'hA000_0000 + 32'(w), 0, 1'b1);
        chk("t3_full", {56'h0, ctrl_state}, 64'd2);
        chk("t3_count_stalled", {32'h0, word_count}, 64'h0);
        stall = 1'b0;
        send(32'hA000_0005, 0, 1'b1);
        send(32'hBAD0_BAD0, 0, 1'b0);
        finish_load(32'd6);
        chk("t3_wrap_addr", {32'h0, mem_addr}, 64'h0000_0010);

        // loader_done with a backlog
        do_reset();
        stall = 1'b1;
        send(32'h0000_0011, 0, 1'b1);
        send(32'h0000_0022, 0, 1'b1);
        send(32'h0000_0033, 0, 1'b1);
        loader_done = 1'b1;
        repeat (4) @(negedge clk);
        chk("t4_not_done", {63'h0, init_done}, 64'd0);
        chk("t4_not_done_state", {56'h0, ctrl_state}, 64'd0);
        stall = 1'b0;
        finish_load(32'd3);

        // Async reset during M_REQ
        do_reset();
        stall = 1'b1;
        send(32'h0000_0055, 0, 1'b1);
        for (i = 0; i < 20 && !mem_req; i++)
            @(negedge clk);
        chk("t6_req_high", {63'h0, mem_req}, 64'd1);
        resetn = 1'b0;
        #1;
        chk("t6_req_drop", {63'h0, mem_req}, 64'd0);
        chk("t6_addr", {32'h0, mem_addr}, {32'h0, BASE});
        chk("t6_wdata", {32'h0, mem_wdata}, 64'h0);
        chk("t6_state", {56'h0, ctrl_state}, 64'd0);
        chk("t6_count", {32'h0, word_count}, 64'h0);
        do_reset();
        send(32'd1, 0, 1'b1);
        send(32'd2, 0, 1'b1);
        send(32'd3, 0, 1'b1);
        finish_load(32'd3);

        // DONE ignores further loader strobes
        word_data = 32'hFFFF_0000;
        word_we = 1'b1;
        repeat (3) @(negedge clk);
        chk("done_ignores_we", {56'h0, ctrl_state}, 64'd3);
        chk("done_no_req", {63'h0, mem_req}, 64'd0);
        chk("done_count", {32'h0, word_count}, 64'd3);
        word_we = 1'b0;

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
